reg_wb_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/wb_scoreboard.sv | 51 +++++
 rtl/reg_wb_arbiter.sv | 107 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file constants and writeback-arbiter types for the CPU core.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    // Round-robin priority pointer: which requester wins a tie.
    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } pri_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with set/clear ports
// and the RAW/WAW hazard check used to gate instruction issue.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    localparam int NREG  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [NREG-1:0]   busy_mask,
    output logic              hazard,
    output logic              chk_busy
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // Set wins on paper, but issue gating guarantees set and clear never hit
    // the same register in one cycle.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            assign busy_next[gi] =
                (set_en && (set_addr == ADDR_W'(gi))) ? 1'b1 :
                (clr_en && (clr_addr == ADDR_W'(gi))) ? 1'b0 :
                busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_mask = busy_reg;
    assign hazard    = busy_reg[rs1] || busy_reg[rs2] || (rd_en && busy_reg[rd]);
    assign chk_busy  = busy_reg[chk_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port controller: round-robin ALU/load writeback
// arbitration, registered write port, and scoreboard-based issue gating.
module reg_wb_arbiter #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              iss_rd_en,
    output logic              iss_ready,
    input  logic              alu_wb_valid,
    input  logic [ADDR_W-1:0] alu_wb_addr,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic              alu_wb_ready,
    input  logic              mem_wb_valid,
    input  logic [ADDR_W-1:0] mem_wb_addr,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_wb_ready,
    output logic              reg_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic [NREG-1:0]   busy_mask,
    output logic              wb_err
);
    import cpu_pkg::*;

    pri_t              ptr_reg;
    logic              reg_load_reg;
    logic [ADDR_W-1:0] reg_addr_reg;
    logic [DATA_W-1:0] reg_data_reg;
    logic              clr_owed_reg;
    logic              wb_err_reg;

    logic              alu_gnt;
    logic              mem_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_busy;
    logic              hazard;
    logic              issue_fire;

    always_comb begin
        alu_gnt  = rst_n && alu_wb_valid && (!mem_wb_valid || (ptr_reg == PRI_ALU));
        mem_gnt  = rst_n && mem_wb_valid && !alu_gnt;
        any_gnt  = alu_gnt || mem_gnt;
        gnt_addr = alu_gnt ? alu_wb_addr : mem_wb_addr;
        gnt_data = alu_gnt ? alu_wb_data : mem_wb_data;
    end

    assign iss_ready  = !reg_load_reg && !hazard;
    assign issue_fire = iss_valid && iss_ready && iss_rd_en;

    // The clear is decided at grant time so that a spurious write cannot wipe
    // a busy bit that an issue sets in the same cycle as the grant.
    wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (issue_fire),
        .set_addr  (iss_rd),
        .clr_en    (reg_load_reg && clr_owed_reg),
        .clr_addr  (reg_addr_reg),
        .rs1       (iss_rs1),
        .rs2       (iss_rs2),
        .rd        (iss_rd),
        .rd_en     (iss_rd_en),
        .chk_addr  (gnt_addr),
        .busy_mask (busy_mask),
        .hazard    (hazard),
        .chk_busy  (gnt_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg      <= PRI_MEM;
            reg_load_reg <= 1'b0;
            reg_addr_reg <= '0;
            reg_data_reg <= '0;
            clr_owed_reg <= 1'b0;
            wb_err_reg   <= 1'b0;
        end else begin
            reg_load_reg <= any_gnt;
            clr_owed_reg <= any_gnt && gnt_busy;
            if (any_gnt) begin
                reg_addr_reg <= gnt_addr;
                reg_data_reg <= gnt_data;
                ptr_reg      <= alu_gnt ? PRI_MEM : PRI_ALU;
                if (!gnt_busy) begin
                    wb_err_reg <= 1'b1;
                end
            end
        end
    end

    assign alu_wb_ready = alu_gnt;
    assign mem_wb_ready = mem_gnt;
    assign reg_load     = reg_load_reg;
    assign reg_addr     = reg_addr_reg;
    assign reg_data     = reg_data_reg;
    assign wb_err       = wb_err_reg;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_reg_wb_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rs1, iss_rs2, iss_rd;
    logic              iss_rd_en;
    logic              iss_ready;
    logic              alu_wb_valid;
    logic [ADDR_W-1:0] alu_wb_addr;
    logic [DATA_W-1:0] alu_wb_data;
    logic              alu_wb_ready;
    logic              mem_wb_valid;
    logic [ADDR_W-1:0] mem_wb_addr;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_ready;
    logic              reg_load;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic [NREG-1:0]   busy_mask;
    logic              wb_err;

    reg_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_rd_en(iss_rd_en), .iss_ready(iss_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr),
        .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
        .reg_load(reg_load), .reg_addr(reg_addr), .reg_data(reg_data),
        .busy_mask(busy_mask), .wb_err(wb_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: set of outstanding destinations, who gets the next
    // tie, and the single write in flight to the register file.
    bit                m_busy[NREG];
    bit                m_fav_alu;
    bit                m_err;
    bit                m_load;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_clear_owed;
    bit                last_ag, last_mg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
        return !m_load && !m_busy[iss_rs1] && !m_busy[iss_rs2] && !(iss_rd_en && m_busy[iss_rd]);
    endfunction

    function automatic bit m_alu_gnt();
        if (!rst_n || !alu_wb_valid) return 1'b0;
        return !mem_wb_valid || m_fav_alu;
    endfunction

    function automatic bit m_mem_gnt();
        if (!rst_n || !mem_wb_valid) return 1'b0;
        return !alu_wb_valid || !m_fav_alu;
    endfunction

    function automatic logic [NREG-1:0] m_mask();
        logic [NREG-1:0] m = '0;
        for (int i = 0; i < NREG; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_fav_alu = 1'b0; m_err = 1'b0; m_load = 1'b0;
        m_addr = '0; m_data = '0; m_clear_owed = 1'b0;
    endtask

    task automatic compare_model();
        last_ag = m_alu_gnt();
        last_mg = m_mem_gnt();
        chk("iss_ready", 32'(iss_ready), 32'(m_ready()));
        chk("alu_wb_ready", 32'(alu_wb_ready), 32'(last_ag));
        chk("mem_wb_ready", 32'(mem_wb_ready), 32'(last_mg));
        chk("reg_load", 32'(reg_load), 32'(m_load));
        chk("reg_addr", 32'(reg_addr), 32'(m_addr));
        chk("reg_data", 32'(reg_data), 32'(m_data));
        chk("busy_mask", 32'(busy_mask), 32'(m_mask()));
        chk("wb_err", 32'(wb_err), 32'(m_err));
    endtask

    task automatic model_update();
        bit old_busy[NREG];
        bit rdy, ag, mg;
        logic [ADDR_W-1:0] wa;
        old_busy = m_busy;
        rdy = m_ready();
        ag = m_alu_gnt();
        mg = m_mem_gnt();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_load && m_clear_owed) m_busy[m_addr] = 1'b0;
        if (iss_valid && rdy && iss_rd_en) m_busy[iss_rd] = 1'b1;
        if (ag || mg) begin
            wa = ag ? alu_wb_addr : mem_wb_addr;
            m_addr = wa;
            m_data = ag ? alu_wb_data : mem_wb_data;
            m_clear_owed = old_busy[wa];
            if (!old_busy[wa]) m_err = 1'b1;
            m_load = 1'b1;
            m_fav_alu = mg;
        end else begin
            m_load = 1'b0;
            m_clear_owed = 1'b0;
        end
    endtask

    task automatic tick();
        #1;
        compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rd);
        iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = rd; iss_rd_en = 1'b1;
        tick();
        iss_valid = 1'b0; iss_rd_en = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        logic [ADDR_W-1:0] lst[NREG];
        int cnt = 0;
        for (int i = 0; i < NREG; i++) if (m_busy[i]) begin lst[cnt] = ADDR_W'(i); cnt++; end
        if (cnt > 0 && $urandom_range(0, 7) != 0) return lst[$urandom_range(0, cnt - 1)];
        return ADDR_W'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        model_reset();
        rst_n = 1'b0; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_rd_en = 1'b0;
        alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
        mem_wb_valid = 1'b0; mem_wb_addr = '0; mem_wb_data = '0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset and idle
        #1;
        chk("idle busy_mask", 32'(busy_mask), 32'h00);
        chk("idle reg_load", 32'(reg_load), 32'h0);
        chk("idle iss_ready", 32'(iss_ready), 32'h1);
        chk("idle wb_err", 32'(wb_err), 32'h0);
        tick();

        // RAW stall on r3
        issue(3'd3);
        iss_valid = 1'b1; iss_rs1 = 3'd3;
        #1 chk("raw stall iss_ready", 32'(iss_ready), 32'h0);
        chk("raw busy_mask", 32'(busy_mask), 32'h08);
        tick();
        iss_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_addr = 3'd3; alu_wb_data = 16'h1234;
        #1 chk("raw alu grant", 32'(alu_wb_ready), 32'h1);
        tick();
        alu_wb_valid = 1'b0;
        #1 chk("raw reg_load", 32'(reg_load), 32'h1);
        chk("raw reg_addr", 32'(reg_addr), 32'h3);
        chk("raw reg_data", 32'(reg_data), 32'h1234);
        chk("raw N+1 iss_ready", 32'(iss_ready), 32'h0);
        $display("write r%0d <= %h", reg_addr, reg_data);
        tick();
        #1 chk("raw N+2 iss_ready", 32'(iss_ready), 32'h1);
        chk("raw N+2 busy_mask", 32'(busy_mask), 32'h00);
        iss_rs1 = '0;
        tick();

        // Contention: mem favoured first
        issue(3'd1);
        issue(3'd2);
        alu_wb_valid = 1'b1; alu_wb_addr = 3'd1; alu_wb_data = 16'h00AA;
        mem_wb_valid = 1'b1; mem_wb_addr = 3'd2; mem_wb_data = 16'h00BB;
        #1 chk("cont mem first", 32'(mem_wb_ready), 32'h1);
        chk("cont alu waits", 32'(alu_wb_ready), 32'h0);
        tick();
        mem_wb_valid = 1'b0;
        #1 chk("cont alu second", 32'(alu_wb_ready), 32'h1);
        chk("cont load1", 32'(reg_load), 32'h1);
        chk("cont addr1", 32'(reg_addr), 32'h2);
        chk("cont data1", 32'(reg_data), 32'h00BB);
        $display("write r%0d <= %h", reg_addr, reg_data);
        tick();
        alu_wb_valid = 1'b0;
        #1 chk("cont load2", 32'(reg_load), 32'h1);
        chk("cont addr2", 32'(reg_addr), 32'h1);
        chk("cont data2", 32'(reg_data), 32'h00AA);
        $display("write r%0d <= %h", reg_addr, reg_data);
        tick();
        #1 chk("cont busy clear", 32'(busy_mask), 32'h00);
        chk("cont load off", 32'(reg_load), 32'h0);
        tick();

        // Spurious write to r5
        alu_wb_valid = 1'b1; alu_wb_addr = 3'd5; alu_wb_data = 16'h5555;
        tick();
        alu_wb_valid = 1'b0;
        #1 chk("spur reg_load", 32'(reg_load), 32'h1);
        chk("spur reg_addr", 32'(reg_addr), 32'h5);
        chk("spur wb_err", 32'(wb_err), 32'h1);
        chk("spur busy_mask", 32'(busy_mask), 32'h00);
        $display("write r%0d <= %h (spurious)", reg_addr, reg_data);
        tick();

        // Continuous contention: strict alternation starting with mem
        alu_wb_valid = 1'b1; alu_wb_addr = 3'd6; alu_wb_data = 16'h0066;
        mem_wb_valid = 1'b1; mem_wb_addr = 3'd7; mem_wb_data = 16'h0077;
        for (int i = 0; i < 6; i++) begin
            #1 chk("alt mem", 32'(mem_wb_ready), 32'(i % 2 == 0));
            chk("alt alu", 32'(alu_wb_ready), 32'(i % 2 == 1));
            if (i > 0) chk("alt reg_load", 32'(reg_load), 32'h1);
            tick();
        end
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        tick();
        #1 chk("err sticky", 32'(wb_err), 32'h1);

        // Reset mid-operation with pointer favouring alu
        mem_wb_valid = 1'b1; mem_wb_addr = 3'd7;
        tick();
        mem_wb_valid = 1'b0;
        tick();
        issue(3'd2);
        issue(3'd3);
        alu_wb_valid = 1'b1; alu_wb_addr = 3'd2; alu_wb_data = 16'h2222;
        rst_n = 1'b0;
        #1 chk("rst pre busy", 32'(busy_mask), 32'h0C);
        chk("rst no grant", 32'(alu_wb_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        mem_wb_valid = 1'b1; mem_wb_addr = 3'd3; mem_wb_data = 16'h3333;
        #1 chk("rst busy_mask", 32'(busy_mask), 32'h00);
        chk("rst reg_load", 32'(reg_load), 32'h0);
        chk("rst wb_err", 32'(wb_err), 32'h0);
        chk("rst ptr mem", 32'(mem_wb_ready), 32'h1);
        chk("rst ptr alu", 32'(alu_wb_ready), 32'h0);
        tick();
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 1500; c++) begin
            bit rst_prev;
            rst_prev = rst_n;
            rst_n = ($urandom_range(0, 99) != 0);
            iss_valid = $urandom_range(0, 1);
            iss_rs1 = ADDR_W'($urandom_range(0, NREG - 1));
            iss_rs2 = ADDR_W'($urandom_range(0, NREG - 1));
            iss_rd  = ADDR_W'($urandom_range(0, NREG - 1));
            iss_rd_en = $urandom_range(0, 1);
            if (!(alu_wb_valid && !last_ag && rst_prev)) begin
                alu_wb_valid = ($urandom_range(0, 2) == 0);
                alu_wb_addr = pick_addr();
                alu_wb_data = DATA_W'($urandom);
            end
            if (!(mem_wb_valid && !last_mg && rst_prev)) begin
                mem_wb_valid = ($urandom_range(0, 2) == 0);
                mem_wb_addr = pick_addr();
                mem_wb_data = DATA_W'($urandom);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
